oddr_x2_tx_gearbox: RTL and testbench
=====================================

Name: oddr_x2_tx_gearbox

Overview:
- Single-clock 4:1 transmit gearbox. It serializes 4-bit parallel words onto a 1-bit output stream, one bit per clock.
- It is the transmit-side counterpart of the team's 1:4 input gearbox with word alignment. It drives the serial link that gearbox deserializes.
- Supports a continuous training pattern for link bring-up and a one-bit boundary slip on request, so receiver word alignment can be exercised from the transmit side.

Parameters:
- TRAIN_PATTERN, 4'b0011, word sent repeatedly while TRAIN is high; bit 0 is transmitted first.
- IDLE_BIT, 1'b0, level driven on Q when no word is being transmitted.

Ports:
- SCLK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  reset, synchronous, active-low.
- D0  input  1  word bit 0, transmitted first.
- D1  input  1  word bit 1.
- D2  input  1  word bit 2.
- D3  input  1  word bit 3, transmitted last.
- DVALID  input  1  parallel word on D0..D3 is valid.
- DREADY  output  1  gearbox accepts a word this cycle. Combinational from state, never from DVALID.
- TRAIN  input  1  level: send TRAIN_PATTERN instead of user data.
- ALIGNWD  input  1  a rising edge requests a one-bit boundary slip.
- Q  output  1  serial data, registered.
- QVALID  output  1  Q carries a data or training bit, registered.
- WSTART  output  1  Q carries bit 0 of a word, registered.

Behaviour:
- Reset: on a rising SCLK edge with RSTN=0, all registers clear.
  - Q=IDLE_BIT, QVALID=0, WSTART=0; DREADY=0 while RSTN=0.
  - state=IDLE, phase=0, shift register=0, slip_pending=0, ALIGNWD history=0.
- Reset mid-word: the word in flight is dropped, with no partial completion. The first cycle after release behaves as IDLE.
- State register: IDLE, SHIFT, TRAIN, SLIP. phase is a 2-bit counter, 0..3, that wraps 3 to 0.
- Word boundary (bnd) is 1 when any of these hold:
  - state=IDLE;
  - state=SLIP;
  - state is SHIFT or TRAIN and phase=3.
- DREADY = bnd and RSTN and not TRAIN and not slip_pending.
- Slip request: slip_pending sets on an ALIGNWD 0 to 1 transition, sampled on SCLK.
  - Extra edges while pending coalesce into one slip.
  - slip_pending clears on the cycle SLIP is entered.
- Decisions at bnd, in priority order:
  - 1. slip_pending set: go to SLIP. For 1 cycle Q=IDLE_BIT, QVALID=0, WSTART=0. This shifts all later word boundaries by exactly one bit time.
  - 2. TRAIN=1: go to TRAIN and load TRAIN_PATTERN. phase=0.
  - 3. DVALID=1 (DREADY is high): go to SHIFT and load {D3,D2,D1,D0}. phase=0.
  - 4. Otherwise: go to IDLE. Q=IDLE_BIT, QVALID=0.
- Latency: a word accepted on edge k has bit 0 on Q after edge k+1, and bit 3 after edge k+4.
  - If DVALID is held high, back-to-back words are gapless: 4 bits per 4 clocks.
- Shifting, in SHIFT and TRAIN: one bit per clock, in order bit0, bit1, bit2, bit3.
  - QVALID=1 for every bit.
  - WSTART=1 only with bit 0.
- TRAIN is sampled only at bnd. A word in flight always completes. Dropping TRAIN takes effect at the next boundary.
- ALIGNWD together with TRAIN: the slip is applied first, then training resumes. Training words are therefore also shifted by one bit.
- DVALID together with TRAIN at bnd: TRAIN wins, DREADY=0, and the word stays pending upstream. No data is lost.
- DVALID low when a word finishes: IDLE inserts no extra delay. A word accepted in IDLE starts on the next edge.

Test Plan:
- Reset, then words 4'hA and 4'h5 with DVALID held high → Q sequence 0,1,0,1, 1,0,1,0 with no gap, QVALID=1 for all 8 bits, WSTART high on bits 1 and 5. Then DREADY high on those words' accept cycles.
- TRAIN=1 for 12 cycles with DVALID=1 and D=4'hF → Q repeats 1,1,0,0 three times, DREADY=0 throughout, no word accepted. After TRAIN drops, 4'hF is sent at the next boundary.
- Single ALIGNWD pulse during the stream of 4'hA words → exactly one cycle with QVALID=0 and Q=IDLE_BIT at the next boundary. All later WSTART pulses are one cycle later than before.
- Three ALIGNWD pulses within one word → only one slip cycle is inserted.
- RSTN=0 during phase 2 of a 4'h6 word → next edge gives Q=0, QVALID=0, WSTART=0. After release with DVALID=1 and D=4'h9, Q gives 1,0,0,1 starting 1 cycle after the accept.
- DVALID toggling every other cycle → no duplicated or dropped words. Each accepted word appears on Q exactly once, in order.

Source files
------------

// File: rtl/oddr_x2_tx_gearbox_if.sv
// ---------------------------------------------------------------------------
// oddr_x2_tx_gearbox_if
// Parallel-word input handshake, control levels and serial output of the
// 4:1 transmit gearbox.
//   D0..D3   word bits, D0 transmitted first
//   DVALID   word on D0..D3 is valid
//   DREADY   gearbox accepts a word this cycle (combinational in the gearbox)
//   TRAIN    send the training pattern instead of user data
//   ALIGNWD  rising edge requests a one-bit boundary slip
//   Q        serial data
//   QVALID   Q carries a data or training bit
//   WSTART   Q carries bit 0 of a word
// master: upstream word source / link consumer; slave: the gearbox.
// ---------------------------------------------------------------------------
interface oddr_x2_tx_gearbox_if;
    logic D0;
    logic D1;
    logic D2;
    logic D3;
    logic DVALID;
    logic DREADY;
    logic TRAIN;
    logic ALIGNWD;
    logic Q;
    logic QVALID;
    logic WSTART;

    modport master (
        output D0, D1, D2, D3, DVALID, TRAIN, ALIGNWD,
        input  DREADY, Q, QVALID, WSTART
    );

    modport slave (
        input  D0, D1, D2, D3, DVALID, TRAIN, ALIGNWD,
        output DREADY, Q, QVALID, WSTART
    );
endinterface

// File: rtl/oddr_x2_tx_gearbox.sv
// ---------------------------------------------------------------------------
// oddr_x2_tx_gearbox
// Single-clock 4:1 transmit gearbox: serializes 4-bit words onto a 1-bit
// stream, bit 0 first, one bit per clock. Supports a continuous training
// pattern and a one-bit boundary slip for receiver alignment bring-up.
// Ports:
//   SCLK  clock, all state updates on the rising edge
//   RSTN  synchronous active-low reset
//   bus   oddr_x2_tx_gearbox_if.slave (D0..D3, DVALID, DREADY, TRAIN,
//         ALIGNWD in; Q, QVALID, WSTART registered out; DREADY from state)
// ---------------------------------------------------------------------------
module oddr_x2_tx_gearbox #(
    parameter logic [3:0] TRAIN_PATTERN = 4'b0011,
    parameter logic       IDLE_BIT      = 1'b0
) (
    input logic                       SCLK,
    input logic                       RSTN,
    oddr_x2_tx_gearbox_if.slave       bus
);
    localparam int unsigned WORD_W  = 4;
    localparam int unsigned PHASE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TRAIN = 2'd2,
        ST_SLIP  = 2'd3
    } state_t;

    state_t              state;
    logic [PHASE_W-1:0]  phase;
    logic [WORD_W-1:0]   sreg;
    logic                slip_pending;
    logic                align_d;
    logic                q_r;
    logic                qvalid_r;
    logic                wstart_r;

    logic                bnd_c;
    logic                dready_c;
    logic                align_rise_c;

    // Word boundary: every IDLE/SLIP cycle, or the last bit of a word.
    always_comb begin
        bnd_c = 1'b0;
        case (state)
            ST_IDLE, ST_SLIP: bnd_c = 1'b1;
            default:          bnd_c = (phase == PHASE_W'(3));
        endcase
    end

    assign dready_c     = bnd_c & RSTN & ~bus.TRAIN & ~slip_pending;
    assign align_rise_c = bus.ALIGNWD & ~align_d;

    // FSM, shift register, slip request and registered serial outputs.
    always_ff @(posedge SCLK) begin
        if (!RSTN) begin
            state        <= ST_IDLE;
            phase        <= '0;
            sreg         <= '0;
            slip_pending <= 1'b0;
            align_d      <= 1'b0;
            q_r          <= IDLE_BIT;
            qvalid_r     <= 1'b0;
            wstart_r     <= 1'b0;
        end else begin
            align_d <= bus.ALIGNWD;

            // Output the bit selected by the current phase; IDLE and SLIP
            // emit one idle bit time each.
            if (state == ST_SHIFT || state == ST_TRAIN) begin
                q_r      <= sreg[phase];
                qvalid_r <= 1'b1;
                wstart_r <= (phase == PHASE_W'(0));
            end else begin
                q_r      <= IDLE_BIT;
                qvalid_r <= 1'b0;
                wstart_r <= 1'b0;
            end

            if (bnd_c) begin
                phase <= '0;
                if (slip_pending) begin
                    state <= ST_SLIP;
                end else if (bus.TRAIN) begin
                    state <= ST_TRAIN;
                    sreg  <= TRAIN_PATTERN;
                end else if (bus.DVALID) begin
                    state <= ST_SHIFT;
                    sreg  <= {bus.D3, bus.D2, bus.D1, bus.D0};
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                phase <= phase + PHASE_W'(1);
            end

            // An edge arriving while a slip is already pending, including
            // the cycle SLIP is entered, folds into that slip.
            if (bnd_c && slip_pending) begin
                slip_pending <= 1'b0;
            end else if (align_rise_c) begin
                slip_pending <= 1'b1;
            end
        end
    end

    assign bus.DREADY = dready_c;
    assign bus.Q      = q_r;
    assign bus.QVALID = qvalid_r;
    assign bus.WSTART = wstart_r;

endmodule

// File: tb/tb_oddr_x2_tx_gearbox.sv
// ---------------------------------------------------------------------------
// tb_oddr_x2_tx_gearbox
// Directed, table-driven bench for the 4:1 transmit gearbox. Each table row
// gives the inputs for one clock cycle, the DREADY expected during that
// cycle, and Q/QVALID/WSTART expected just after the rising edge.
// ---------------------------------------------------------------------------
module tb_oddr_x2_tx_gearbox;
    logic SCLK = 1'b0;
    logic RSTN;

    oddr_x2_tx_gearbox_if bus ();

    oddr_x2_tx_gearbox dut (
        .SCLK (SCLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 SCLK = ~SCLK;

    typedef struct {
        logic       rstn;
        logic [3:0] d;
        logic       dv;
        logic       train;
        logic       align;
        logic       e_rdy;
        logic       e_q;
        logic       e_qv;
        logic       e_ws;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic rstn, input logic [3:0] d, input logic dv,
                       input logic train, input logic align, input logic e_rdy,
                       input logic e_q, input logic e_qv, input logic e_ws);
        vec_t v;
        v.rstn = rstn; v.d = d; v.dv = dv; v.train = train; v.align = align;
        v.e_rdy = e_rdy; v.e_q = e_q; v.e_qv = e_qv; v.e_ws = e_ws;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rstn, input logic [3:0] d, input logic dv,
                         input logic train, input logic align);
        RSTN        = rstn;
        bus.D0      = d[0];
        bus.D1      = d[1];
        bus.D2      = d[2];
        bus.D3      = d[3];
        bus.DVALID  = dv;
        bus.TRAIN   = train;
        bus.ALIGNWD = align;
    endtask

    task automatic check_bits(input string name, input int idx,
                              input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    int          ws_steps[6]   = '{2, 6, 11, 15, 20, 24};
    int          idle_steps[3] = '{1, 10, 19};
    int          rdy_steps[6]  = '{1, 5, 10, 14, 19, 23};
    int          q1_steps[10]  = '{3, 5, 7, 9, 12, 14, 16, 18, 21, 23};
    logic [23:0] got_ws, got_qv, got_rdy, got_q;
    logic [23:0] exp_ws, exp_qv, exp_rdy, exp_q;

    initial begin
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset: DREADY low, outputs idle.
        add(0, 4'h0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 4'h0, 0, 0, 0,  0, 0, 0, 0);

        // 4'hA then 4'h5 back to back, then drain to IDLE.
        add(1, 4'hA, 1, 0, 0,  1, 0, 0, 0);
        add(1, 4'h5, 1, 0, 0,  0, 0, 1, 1);
        add(1, 4'h5, 1, 0, 0,  0, 1, 1, 0);
        add(1, 4'h5, 1, 0, 0,  0, 0, 1, 0);
        add(1, 4'h5, 1, 0, 0,  1, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 1);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 0, 0, 0);

        // TRAIN with 4'hF pending: pattern 1,1,0,0 x3, no word accepted.
        add(1, 4'hF, 1, 1, 0,  0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(1, 4'hF, 1, 1, 0,  0, 1, 1, 1);
            add(1, 4'hF, 1, 1, 0,  0, 1, 1, 0);
            add(1, 4'hF, 1, 1, 0,  0, 0, 1, 0);
            add(1, 4'hF, 1, 1, 0,  0, 0, 1, 0);
        end
        // TRAIN dropped mid-word: training word completes, then 4'hF.
        add(1, 4'hF, 1, 0, 0,  0, 1, 1, 1);
        add(1, 4'hF, 1, 0, 0,  0, 1, 1, 0);
        add(1, 4'hF, 1, 0, 0,  0, 0, 1, 0);
        add(1, 4'hF, 1, 0, 0,  1, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 1);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 0, 0, 0);

        // Reset during phase 2 of 4'h6, then 4'h9 after release.
        add(1, 4'h6, 1, 0, 0,  1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 1);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 0);
        add(0, 4'h0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 4'h9, 1, 0, 0,  1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 1);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 0, 0, 0);

        // DVALID toggling: words 3, C, 7, 8, 1 each sent once, in order.
        add(1, 4'h3, 1, 0, 0,  1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 1);
        add(1, 4'hC, 1, 0, 0,  0, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 0);
        add(1, 4'hC, 1, 0, 0,  1, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 1);
        add(1, 4'h7, 1, 0, 0,  0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 0);
        add(1, 4'h7, 1, 0, 0,  1, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 1);
        add(1, 4'h8, 1, 0, 0,  0, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 0);
        add(1, 4'h8, 1, 0, 0,  1, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 1);
        add(1, 4'h1, 1, 0, 0,  0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 0);
        add(1, 4'h1, 1, 0, 0,  1, 1, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 1, 1, 1);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 0, 1, 0);
        add(1, 4'h0, 0, 0, 0,  1, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].d, vecs[i].dv, vecs[i].train, vecs[i].align);
            #1;
            checks++;
            if (bus.DREADY !== vecs[i].e_rdy) begin
                failures++;
                $display("FAIL dready row %0d: got %b expected %b",
                         i, bus.DREADY, vecs[i].e_rdy);
            end
            @(posedge SCLK);
            #1;
            checks++;
            if ({bus.Q, bus.QVALID, bus.WSTART} !==
                {vecs[i].e_q, vecs[i].e_qv, vecs[i].e_ws}) begin
                failures++;
                $display("FAIL q/qvalid/wstart row %0d: got %b%b%b expected %b%b%b",
                         i, bus.Q, bus.QVALID, bus.WSTART,
                         vecs[i].e_q, vecs[i].e_qv, vecs[i].e_ws);
            end
        end

        // Slip sequence on a continuous 4'hA stream: one ALIGNWD pulse at
        // step 7, then three rising edges (steps 14, 16, 18) within one word.
        exp_ws  = '0;
        exp_qv  = '1;
        exp_rdy = '0;
        exp_q   = '0;
        foreach (ws_steps[i])   exp_ws[5'(ws_steps[i] - 1)]    = 1'b1;
        foreach (idle_steps[i]) exp_qv[5'(idle_steps[i] - 1)]  = 1'b0;
        foreach (rdy_steps[i])  exp_rdy[5'(rdy_steps[i] - 1)]  = 1'b1;
        foreach (q1_steps[i])   exp_q[5'(q1_steps[i] - 1)]     = 1'b1;
        got_ws  = '0;
        got_qv  = '0;
        got_rdy = '0;
        got_q   = '0;
        for (int s = 1; s <= 24; s++) begin
            drive(1'b1, 4'hA, 1'b1, 1'b0, (s == 7 || s == 14 || s == 16 || s == 18));
            #1;
            got_rdy[5'(s - 1)] = bus.DREADY;
            @(posedge SCLK);
            #1;
            got_q[5'(s - 1)]  = bus.Q;
            got_qv[5'(s - 1)] = bus.QVALID;
            got_ws[5'(s - 1)] = bus.WSTART;
        end
        check_bits("slip_wstart", 24, got_ws, exp_ws);
        check_bits("slip_qvalid", 24, got_qv, exp_qv);
        check_bits("slip_dready", 24, got_rdy, exp_rdy);
        check_bits("slip_q",      24, got_q,  exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
